// File: rtl/amber_core.sv
// amber_core: minimal CHERI-style 48-bit core with private instruction memory,
// data/capability/special register files and a two-cycle FETCH/EXEC sequencer.

module amber_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [23:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [23:0]   rdata
);
    logic [23:0] r_mem [DEPTH];

    // Loader write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule

module amber_regdr (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [47:0] wdata,
    input  logic [3:0]  raddr,
    output logic [47:0] rdata
);
    logic [47:0] r_dr [16];

    // Data register file with reset clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_dr[i] <= 48'd0;
            end
        end else if (we) begin
            r_dr[waddr] <= wdata;
        end
    end

    assign rdata = r_dr[raddr];
endmodule

module amber_regcr (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel,
    input  logic        cur_we,
    input  logic [47:0] cur_wdata,
    output logic [47:0] base,
    output logic [47:0] len,
    output logic [47:0] cur,
    output logic [23:0] perms,
    output logic [23:0] attr,
    output logic        tag
);
    logic [47:0] r_base  [4];
    logic [47:0] r_len   [4];
    logic [47:0] r_cur   [4];
    logic [23:0] r_perms [4];
    logic [23:0] r_attr  [4];
    logic        r_tag   [4];

    // Capability records; only the cursor is architecturally writable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_base[i]  <= 48'd0;
                r_len[i]   <= 48'd0;
                r_cur[i]   <= 48'd0;
                r_perms[i] <= 24'd0;
                r_attr[i]  <= 24'd0;
                r_tag[i]   <= 1'b0;
            end
        end else if (cur_we) begin
            r_cur[sel] <= cur_wdata;
        end
    end

    assign base  = r_base[sel];
    assign len   = r_len[sel];
    assign cur   = r_cur[sel];
    assign perms = r_perms[sel];
    assign attr  = r_attr[sel];
    assign tag   = r_tag[sel];
endmodule

module amber_regsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_we,
    input  logic [47:0] lr_wdata,
    input  logic [47:0] cause_wdata,
    output logic [47:0] tvec
);
    localparam int SR_IDX_LR    = 0;
    localparam int SR_IDX_CAUSE = 1;
    localparam int SR_IDX_TVEC  = 2;

    logic [47:0] r_sr [4];

    // LR and CAUSE are written together on every trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_sr[i] <= 48'd0;
            end
        end else if (trap_we) begin
            r_sr[SR_IDX_LR]    <= lr_wdata;
            r_sr[SR_IDX_CAUSE] <= cause_wdata;
        end
    end

    assign tvec = r_sr[SR_IDX_TVEC];
endmodule

module amber_core #(
    parameter int         IMEM_DEPTH = 256,
    parameter logic [7:0] OPC_MOVSI  = 8'h10,
    parameter logic [7:0] OPC_CINCV  = 8'h40,
    parameter logic [7:0] OPC_HLT    = 8'hFF
) (
    input  logic iw_clk,
    input  logic iw_rst
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_r;
    logic [47:0] pc_r;
    logic [23:0] ir_r;

    logic [23:0] imem_rdata_s;
    logic [47:0] dr_rdata_s;
    logic [47:0] cr_base_s, cr_len_s, cr_cur_s, tvec_s;
    logic [23:0] cr_perms_s, cr_attr_s;
    logic        cr_tag_s;

    logic [7:0]  opc_s;
    logic [47:0] pc_plus1_s, sext_imm_s, new_cur_s;
    logic [48:0] lim_s;
    logic        in_bounds_s;
    logic        dr_we_s, cur_we_s, trap_s, halt_s;
    logic [47:0] cause_s, next_pc_s;
    logic        unused_meta_s;

    amber_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
        .clk   (iw_clk),
        .we    (1'b0),
        .waddr ({AW{1'b0}}),
        .wdata (24'd0),
        .raddr (pc_r[AW-1:0]),
        .rdata (imem_rdata_s)
    );

    amber_regdr u_regdr (
        .clk   (iw_clk),
        .rst   (iw_rst),
        .we    (dr_we_s),
        .waddr (ir_r[15:12]),
        .wdata (sext_imm_s),
        .raddr (ir_r[13:10]),
        .rdata (dr_rdata_s)
    );

    amber_regcr u_regcr (
        .clk       (iw_clk),
        .rst       (iw_rst),
        .sel       (ir_r[15:14]),
        .cur_we    (cur_we_s),
        .cur_wdata (new_cur_s),
        .base      (cr_base_s),
        .len       (cr_len_s),
        .cur       (cr_cur_s),
        .perms     (cr_perms_s),
        .attr      (cr_attr_s),
        .tag       (cr_tag_s)
    );

    amber_regsr u_regsr (
        .clk         (iw_clk),
        .rst         (iw_rst),
        .trap_we     (trap_s),
        .lr_wdata    (pc_r),
        .cause_wdata (cause_s),
        .tvec        (tvec_s)
    );

    assign opc_s       = ir_r[23:16];
    assign pc_plus1_s  = pc_r + 48'd1;
    assign sext_imm_s  = {{36{ir_r[11]}}, ir_r[11:0]};
    assign new_cur_s   = cr_cur_s + dr_rdata_s;
    // Limit is one bit wider so base+len cannot wrap; the upper bound is exclusive.
    assign lim_s       = {1'b0, cr_base_s} + {1'b0, cr_len_s};
    assign in_bounds_s = (new_cur_s >= cr_base_s) && ({1'b0, new_cur_s} < lim_s);
    // Permissions and attributes are carried but not checked by CINCv.
    assign unused_meta_s = ^{cr_perms_s, cr_attr_s};

    // Execute-stage decode: write enables, trap cause and next PC.
    always_comb begin
        dr_we_s   = 1'b0;
        cur_we_s  = 1'b0;
        trap_s    = 1'b0;
        halt_s    = 1'b0;
        cause_s   = 48'd0;
        next_pc_s = pc_r;
        if (state_r == ST_EXEC) begin
            case (opc_s)
                OPC_MOVSI: begin
                    dr_we_s   = 1'b1;
                    next_pc_s = pc_plus1_s;
                end
                OPC_CINCV: begin
                    if (!cr_tag_s) begin
                        trap_s    = 1'b1;
                        cause_s   = 48'd1;
                        next_pc_s = tvec_s;
                    end else if (in_bounds_s) begin
                        cur_we_s  = 1'b1;
                        next_pc_s = pc_plus1_s;
                    end else begin
                        trap_s    = 1'b1;
                        cause_s   = 48'd2;
                        next_pc_s = tvec_s;
                    end
                end
                OPC_HLT: begin
                    halt_s = 1'b1;
                end
                default: begin
                    trap_s    = 1'b1;
                    cause_s   = 48'd3;
                    next_pc_s = tvec_s;
                end
            endcase
        end else begin
            halt_s = 1'b0;
        end
    end

    // Sequencer: FETCH latches IR, EXEC retires, HALT holds until reset.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_r <= ST_FETCH;
            pc_r    <= 48'd0;
            ir_r    <= 24'd0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    ir_r    <= imem_rdata_s;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    pc_r    <= next_pc_s;
                    state_r <= halt_s ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_amber_core.sv
// Directed bench for amber_core: an instruction-level ISA model is stepped once per
// retired instruction and compared against the core's architectural state.

module tb_amber_core;
    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction-level reference model.
    logic [23:0] m_imem [256];
    logic [47:0] m_dr   [16];
    logic [47:0] m_base [4];
    logic [47:0] m_len  [4];
    logic [47:0] m_cur  [4];
    logic        m_tag  [4];
    logic [47:0] m_sr   [4];
    logic [47:0] m_pc;
    logic        m_halt;

    amber_core dut (
        .iw_clk (iw_clk),
        .iw_rst (iw_rst)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear_regs();
        for (int i = 0; i < 16; i++) m_dr[i] = 48'd0;
        for (int i = 0; i < 4; i++) begin
            m_base[i] = 48'd0; m_len[i] = 48'd0; m_cur[i] = 48'd0;
            m_tag[i] = 1'b0;   m_sr[i] = 48'd0;
        end
        m_pc   = 48'd0;
        m_halt = 1'b0;
    endtask

    task automatic model_trap(input logic [47:0] cause);
        m_sr[0] = m_pc;
        m_sr[1] = cause;
        m_pc    = m_sr[2];
    endtask

    // One whole instruction, using plain integer arithmetic on 64-bit values.
    task automatic model_step();
        logic [23:0] ir;
        longint      imm, nw, lo, hi;
        int          c, r;
        if (m_halt) return;
        ir = m_imem[m_pc[7:0]];
        case (ir[23:16])
            8'h10: begin
                imm = longint'(ir[11:0]);
                if (imm >= 2048) imm = imm - 4096;
                m_dr[ir[15:12]] = imm[47:0];
                m_pc = m_pc + 48'd1;
            end
            8'h40: begin
                c  = int'(ir[15:14]);
                r  = int'(ir[13:10]);
                nw = (longint'(m_cur[c]) + longint'(m_dr[r])) % (longint'(1) << 48);
                lo = longint'(m_base[c]);
                hi = lo + longint'(m_len[c]);
                if (!m_tag[c])              model_trap(48'd1);
                else if (nw < lo || nw >= hi) model_trap(48'd2);
                else begin
                    m_cur[c] = nw[47:0];
                    m_pc = m_pc + 48'd1;
                end
            end
            8'hFF: m_halt = 1'b1;
            default: model_trap(48'd3);
        endcase
    endtask

    task automatic compare_state(input string tname);
        chk({tname, ".pc"},    dut.pc_r,                m_pc);
        chk({tname, ".lr"},    dut.u_regsr.r_sr[0],     m_sr[0]);
        chk({tname, ".cause"}, dut.u_regsr.r_sr[1],     m_sr[1]);
        chk({tname, ".cur0"},  dut.u_regcr.r_cur[0],    m_cur[0]);
        chk({tname, ".dr1"},   dut.u_regdr.r_dr[1],     m_dr[1]);
    endtask

    task automatic load_prog(input logic [23:0] i0, input logic [23:0] i1, input logic [23:0] i2,
                             input logic [23:0] i8);
        for (int i = 0; i < 256; i++) m_imem[i] = 24'h000000;
        m_imem[0] = i0; m_imem[1] = i1; m_imem[2] = i2; m_imem[8] = i8;
        for (int i = 0; i < 256; i++) dut.u_imem.r_mem[i] = m_imem[i];
    endtask

    // Reset, then preload CR0/TVEC between the last reset edge and the first fetch.
    task automatic start_test(input logic tag, input logic [47:0] base, input logic [47:0] len,
                              input logic [47:0] cur, input logic [47:0] tvec);
        iw_rst = 1'b1;
        repeat (2) @(posedge iw_clk);
        @(negedge iw_clk);
        model_clear_regs();
        m_base[0] = base; m_len[0] = len; m_cur[0] = cur; m_tag[0] = tag; m_sr[2] = tvec;
        dut.u_regcr.r_base[0]  = base;
        dut.u_regcr.r_len[0]   = len;
        dut.u_regcr.r_cur[0]   = cur;
        dut.u_regcr.r_tag[0]   = tag;
        dut.u_regcr.r_perms[0] = 24'h000007;
        dut.u_regsr.r_sr[2]    = tvec;
        iw_rst = 1'b0;
    endtask

    task automatic run_steps(input string tname, input int n);
        for (int s = 0; s < n; s++) begin
            repeat (2) @(posedge iw_clk);
            @(negedge iw_clk);
            model_step();
            compare_state(tname);
        end
    endtask

    localparam logic [23:0] MOV5   = 24'h101005;
    localparam logic [23:0] MOV4   = 24'h101004;
    localparam logic [23:0] MOV2   = 24'h101002;
    localparam logic [23:0] MOVM1  = 24'h101FFF;
    localparam logic [23:0] CINC01 = 24'h400400;
    localparam logic [23:0] HLT    = 24'hFF0000;

    initial begin
        int cyc;

        // Reset state.
        load_prog(MOV5, CINC01, HLT, 24'h000000);
        repeat (2) @(posedge iw_clk);
        @(negedge iw_clk);
        chk("reset.pc", dut.pc_r, 48'd0);
        chk("reset.dr1", dut.u_regdr.r_dr[1], 48'd0);
        chk("reset.tag0", {47'd0, dut.u_regcr.r_tag[0]}, 48'd0);

        // Bounds trap: LR must appear within 50 cycles.
        start_test(1'b1, 48'd100, 48'd5, 48'd104, 48'd0);
        cyc = 0;
        while (dut.u_regsr.r_sr[0] == 48'd0 && cyc < 50) begin
            @(negedge iw_clk);
            cyc++;
        end
        chk("bounds.lr_within_50", {47'd0, (cyc < 50)}, 48'd1);

        start_test(1'b1, 48'd100, 48'd5, 48'd104, 48'd0);
        run_steps("bounds", 8);
        chk("bounds.lr_lit", dut.u_regsr.r_sr[0], 48'd1);
        chk("bounds.cause_lit", dut.u_regsr.r_sr[1], 48'd2);
        chk("bounds.cur_lit", dut.u_regcr.r_cur[0], 48'd104);
        chk("bounds.model_not_halted", {47'd0, m_halt}, 48'd0);

        // In-bounds increment reaches HALT.
        load_prog(MOV4, CINC01, HLT, 24'h000000);
        start_test(1'b1, 48'd100, 48'd5, 48'd100, 48'd0);
        run_steps("inb", 5);
        chk("inb.cur_lit", dut.u_regcr.r_cur[0], 48'd104);
        chk("inb.lr_lit", dut.u_regsr.r_sr[0], 48'd0);
        chk("inb.pc_lit", dut.pc_r, 48'd2);

        // Lower bound: cur 100 + (-1) = 99.
        load_prog(MOVM1, CINC01, HLT, 24'h000000);
        start_test(1'b1, 48'd100, 48'd5, 48'd100, 48'd0);
        run_steps("lower", 4);
        chk("lower.dr1_lit", dut.u_regdr.r_dr[1], 48'hFFFF_FFFF_FFFF);
        chk("lower.cause_lit", dut.u_regsr.r_sr[1], 48'd2);
        chk("lower.cur_lit", dut.u_regcr.r_cur[0], 48'd100);

        // Tag clear wins over an in-bounds increment.
        load_prog(MOV2, CINC01, HLT, 24'h000000);
        start_test(1'b0, 48'd100, 48'd5, 48'd100, 48'd0);
        run_steps("tag", 4);
        chk("tag.cause_lit", dut.u_regsr.r_sr[1], 48'd1);
        chk("tag.cur_lit", dut.u_regcr.r_cur[0], 48'd100);

        // Trap vector redirect to HLT at 8.
        load_prog(MOV5, CINC01, HLT, HLT);
        start_test(1'b1, 48'd100, 48'd5, 48'd104, 48'd8);
        run_steps("tvec", 2);
        chk("tvec.pc_after_trap", dut.pc_r, 48'd8);
        run_steps("tvec", 3);
        chk("tvec.pc_halted", dut.pc_r, 48'd8);
        chk("tvec.lr_lit", dut.u_regsr.r_sr[0], 48'd1);

        // Unknown opcode traps with cause 3.
        load_prog(MOV5, 24'h000000, HLT, 24'h000000);
        start_test(1'b1, 48'd100, 48'd5, 48'd104, 48'd0);
        run_steps("illegal", 3);
        chk("illegal.cause_lit", dut.u_regsr.r_sr[1], 48'd3);
        chk("illegal.lr_lit", dut.u_regsr.r_sr[0], 48'd1);

        // Reset asserted while the CINCv is in EXEC.
        load_prog(MOV5, CINC01, HLT, 24'h000000);
        start_test(1'b1, 48'd100, 48'd5, 48'd104, 48'd8);
        repeat (3) @(posedge iw_clk);
        @(negedge iw_clk);
        iw_rst = 1'b1;
        @(posedge iw_clk);
        @(negedge iw_clk);
        chk("rstmid.pc", dut.pc_r, 48'd0);
        chk("rstmid.dr1", dut.u_regdr.r_dr[1], 48'd0);
        chk("rstmid.base0", dut.u_regcr.r_base[0], 48'd0);
        chk("rstmid.cur0", dut.u_regcr.r_cur[0], 48'd0);
        chk("rstmid.tag0", {47'd0, dut.u_regcr.r_tag[0]}, 48'd0);
        chk("rstmid.lr", dut.u_regsr.r_sr[0], 48'd0);
        chk("rstmid.tvec", dut.u_regsr.r_sr[2], 48'd0);
        model_clear_regs();
        iw_rst = 1'b0;
        run_steps("rstmid", 1);
        chk("rstmid.refetch_dr1", dut.u_regdr.r_dr[1], 48'd5);
        chk("rstmid.refetch_pc", dut.pc_r, 48'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
